// File: rtl/uart_cal_pkg.sv
// Shared constants and state encoding for the UART calculator result path.
package uart_cal_pkg;

  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    SIGN,
    DIGIT,
    CR,
    LF
  } fmt_state_e;

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double dabble: one shift/add-3 step per cycle, DATA_W steps after start.
module bin2bcd_seq #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_DIGITS = 10
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    done
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]       bin_q, bin_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    done_q, done_d;

  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start) begin
      bin_d = bin;
      bcd_d = '0;
      cnt_d = CNT_W'(DATA_W);
    end else if (cnt_q != '0) begin
      bin_d  = bin_q << 1;
      bcd_d  = (4*NUM_DIGITS)'({adj, bin_q[DATA_W-1]});
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;

endmodule

// File: rtl/res_ascii_fmt.sv
// Formats an ALU result as signed ASCII decimal and streams it one byte per
// valid/ready handshake, optionally terminated with CR LF.
module res_ascii_fmt
  import uart_cal_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_DIGITS = 10,
  parameter int unsigned SIGNED_EN  = 1,
  parameter int unsigned EOL_EN     = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] calc_res,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              uout_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  fmt_state_e              state_q, state_d;
  logic                    neg_q, neg_d;
  logic [IDX_W-1:0]        idx_q, idx_d, idx_dec, ms_idx;
  logic [7:0]              tx_q, tx_d;
  logic                    valid_q, valid_d;
  logic                    ovr_q, ovr_d;

  logic                    neg_in, start;
  logic [DATA_W-1:0]       mag;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic                    cdone;
  logic [3:0]              dig_ms, dig_cur, dig_nxt;

  // Magnitude is fed straight into the converter on the capture cycle so the
  // first byte appears DATA_W+1 cycles after alu_done.
  assign neg_in = (SIGNED_EN != 0) && calc_res[DATA_W-1];
  assign mag    = neg_in ? -calc_res : calc_res;
  assign start  = alu_done && (state_q == IDLE);

  bin2bcd_seq #(
    .DATA_W    (DATA_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_bcd (
    .clk  (clk),
    .n_rst(n_rst),
    .start(start),
    .bin  (mag),
    .bcd  (bcd),
    .done (cdone)
  );

  // Most significant nonzero digit; stays 0 for a zero value so "0" is emitted.
  always_comb begin
    ms_idx = '0;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) ms_idx = IDX_W'(i);
    end
  end

  assign idx_dec = idx_q - IDX_W'(1);
  assign dig_ms  = bcd[{ms_idx, 2'b00} +: 4];
  assign dig_cur = bcd[{idx_q, 2'b00} +: 4];
  assign dig_nxt = bcd[{idx_dec, 2'b00} +: 4];

  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    valid_d = valid_q;
    ovr_d   = alu_done && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (alu_done) begin
          neg_d   = neg_in;
          state_d = CONV;
        end
      end
      CONV: begin
        if (cdone) begin
          valid_d = 1'b1;
          idx_d   = ms_idx;
          if (neg_q) begin
            state_d = SIGN;
            tx_d    = ASCII_MINUS;
          end else begin
            state_d = DIGIT;
            tx_d    = ASCII_ZERO + {4'h0, dig_ms};
          end
        end
      end
      SIGN: begin
        if (tx_ready) begin
          state_d = DIGIT;
          tx_d    = ASCII_ZERO + {4'h0, dig_cur};
        end
      end
      DIGIT: begin
        if (tx_ready) begin
          if (idx_q != '0) begin
            idx_d = idx_dec;
            tx_d  = ASCII_ZERO + {4'h0, dig_nxt};
          end else if (EOL_EN != 0) begin
            state_d = CR;
            tx_d    = ASCII_CR;
          end else begin
            state_d = IDLE;
            tx_d    = '0;
            valid_d = 1'b0;
          end
        end
      end
      CR: begin
        if (tx_ready) begin
          state_d = LF;
          tx_d    = ASCII_LF;
        end
      end
      LF: begin
        if (tx_ready) begin
          state_d = IDLE;
          tx_d    = '0;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      idx_q   <= '0;
      tx_q    <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign tx_data    = tx_q;
  assign uout_valid = valid_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_res_ascii_fmt.sv
// Directed bench for res_ascii_fmt: signed and unsigned instances share stimulus,
// transferred bytes are scoreboarded against a decimal model.
module tb_res_ascii_fmt;

  logic        clk = 1'b0;
  logic        n_rst, alu_done, tx_ready;
  logic [31:0] calc_res;
  logic [7:0]  d0, d1;
  logic        v0, v1, b0, b1, o0, o1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rx0[$], rx1[$], exp0[$], exp1[$];

  always #5 clk = ~clk;

  res_ascii_fmt #(.DATA_W(32), .NUM_DIGITS(10), .SIGNED_EN(1), .EOL_EN(1)) u_sgn (
    .clk(clk), .n_rst(n_rst), .alu_done(alu_done), .calc_res(calc_res),
    .tx_ready(tx_ready), .tx_data(d0), .uout_valid(v0), .busy(b0), .overrun(o0)
  );

  res_ascii_fmt #(.DATA_W(32), .NUM_DIGITS(10), .SIGNED_EN(0), .EOL_EN(1)) u_uns (
    .clk(clk), .n_rst(n_rst), .alu_done(alu_done), .calc_res(calc_res),
    .tx_ready(tx_ready), .tx_data(d1), .uout_valid(v1), .busy(b1), .overrun(o1)
  );

  // Inputs change just after posedge, so at negedge valid&ready is what the next edge sees.
  always @(negedge clk) begin
    if (n_rst === 1'b1 && tx_ready === 1'b1) begin
      if (v0) rx0.push_back(d0);
      if (v1) rx1.push_back(d1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [31:0] v);
    logic [7:0]      t[$];
    longint unsigned m;
    bit              neg;
    for (int s = 0; s < 2; s++) begin
      t.delete();
      neg = (s == 0) && v[31];
      m   = neg ? (64'h1_0000_0000 - {32'h0, v}) : {32'h0, v};
      do begin
        t.push_front(8'(64'h30 + m % 10));
        m = m / 10;
      end while (m != 0);
      if (neg) t.push_front(8'h2D);
      t.push_back(8'h0D);
      t.push_back(8'h0A);
      foreach (t[k]) begin
        if (s == 0) exp0.push_back(t[k]);
        else        exp1.push_back(t[k]);
      end
    end
  endtask

  task automatic pulse(input logic [31:0] v);
    calc_res = v;
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    exp_push(v);
    pulse(v);
    check("busy_after_capture", {31'h0, b0}, 32'h1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!v0 && n < 100) begin
      tick();
      n++;
    end
    check("valid_timeout", {31'h0, v0}, 32'h1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((b0 || b1) && n < 400) begin
      tick();
      n++;
    end
    check("idle_timeout", (n < 400) ? 32'h1 : 32'h0, 32'h1);
    tick();
  endtask

  task automatic compare_streams(input string tag);
    check({tag, "_len_s"}, rx0.size(), exp0.size());
    check({tag, "_len_u"}, rx1.size(), exp1.size());
    while (rx0.size() > 0 && exp0.size() > 0) check({tag, "_s"}, rx0.pop_front(), exp0.pop_front());
    while (rx1.size() > 0 && exp1.size() > 0) check({tag, "_u"}, rx1.pop_front(), exp1.pop_front());
    rx0.delete(); rx1.delete(); exp0.delete(); exp1.delete();
  endtask

  initial begin
    int lat;
    int n;
    n_rst    = 1'b0;
    alu_done = 1'b0;
    tx_ready = 1'b1;
    calc_res = '0;
    repeat (3) tick();
    check("rst_tx_data", {24'h0, d0}, 32'h0);
    check("rst_valid",   {31'h0, v0}, 32'h0);
    check("rst_busy",    {31'h0, b0}, 32'h0);
    check("rst_overrun", {31'h0, o0}, 32'h0);
    n_rst = 1'b1;
    tick();

    // 123 with first-byte latency measured from the capture edge
    exp_push(32'd123);
    pulse(32'd123);
    check("busy_after_capture", {31'h0, b0}, 32'h1);
    lat = 0;
    while (!v0 && lat < 100) begin
      tick();
      lat++;
    end
    check("first_valid_latency", lat, 33);
    check("first_byte", {24'h0, d0}, 32'h31);
    wait_idle();
    compare_streams("t123");

    send(32'd0);          wait_idle(); compare_streams("t0");
    send(32'hFFFF_FFD3);  wait_idle(); compare_streams("tneg45");
    send(32'h8000_0000);  wait_idle(); compare_streams("tmin");
    send(32'h7FFF_FFFF);  wait_idle(); compare_streams("tmax");

    // Backpressure on the second byte
    exp_push(32'd123);
    pulse(32'd123);
    wait_valid();
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_data",  {24'h0, d0}, 32'h32);
      check("stall_valid", {31'h0, v0}, 32'h1);
      tick();
    end
    tx_ready = 1'b1;
    wait_idle();
    compare_streams("tstall");

    // alu_done during the stream is dropped with a one-cycle overrun
    exp_push(32'd123);
    pulse(32'd123);
    wait_valid();
    calc_res = 32'd77;
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    check("overrun_pulse_s", {31'h0, o0}, 32'h1);
    check("overrun_pulse_u", {31'h0, o1}, 32'h1);
    tick();
    check("overrun_clear", {31'h0, o0}, 32'h0);
    wait_idle();
    compare_streams("tovr");

    // alu_done coincident with the final LF transfer is still dropped
    exp_push(32'd0);
    pulse(32'd0);
    n = 0;
    while (!(v0 && d0 == 8'h0A) && n < 100) begin
      tick();
      n++;
    end
    check("lf_seen", {31'h0, v0}, 32'h1);
    calc_res = 32'd5;
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    check("last_xfer_overrun", {31'h0, o0}, 32'h1);
    check("last_xfer_busy",    {31'h0, b0}, 32'h0);
    tick();
    check("last_xfer_no_capture", {31'h0, b0}, 32'h0);
    wait_idle();
    compare_streams("tlast");

    // Reset mid-conversion
    pulse(32'd5);
    repeat (5) tick();
    n_rst = 1'b0;
    #1;
    check("rst_conv_busy", {31'h0, b0}, 32'h0);
    tick();
    n_rst = 1'b1;
    tick();

    // Reset mid-stream, then a clean restart
    pulse(32'd123);
    wait_valid();
    tick();
    n_rst = 1'b0;
    #1;
    check("rst_mid_data",  {24'h0, d0}, 32'h0);
    check("rst_mid_valid", {31'h0, v0}, 32'h0);
    check("rst_mid_busy",  {31'h0, b0}, 32'h0);
    rx0.delete(); rx1.delete(); exp0.delete(); exp1.delete();
    tick();
    n_rst = 1'b1;
    tick();
    check("post_rst_idle_valid", {31'h0, v0}, 32'h0);
    send(32'd9);
    wait_idle();
    compare_streams("t9");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
